// File: rtl/result_collector.sv
// Responder end of the multiplier result handshake: buffers each strobed
// element of an N x N result, counts distinct arrivals and serves a read port.
module result_collector #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1,
    parameter int CNT_W = $clog2(N * N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] z_out,
    input  logic [IDX_W-1:0] z_i,
    input  logic [IDX_W-1:0] z_j,
    input  logic             z_stb,
    output logic             z_ack,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_i,
    input  logic [IDX_W-1:0] rd_j,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             protocol_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N * N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Indices are only out of range when N is not a power of two.
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return ({{(32 - IDX_W){1'b0}}, idx} < 32'(N));
    endfunction

    state_t                     state_q, state_d;
    logic                       ack_q, ack_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       full_q, full_d;
    logic                       err_q, err_d;
    logic [N-1:0][N-1:0]        written_q, written_d;
    logic [WIDTH-1:0]           rd_data_q, rd_data_d;
    logic [WIDTH-1:0]           buf_q [N][N];

    logic                       cap_s;
    logic                       wr_ok_s;
    logic                       was_written_s;
    logic                       rd_ok_s;

    // Next-state, capture decision and read-port mux.
    always_comb begin
        state_d       = state_q;
        ack_d         = 1'b0;
        count_d       = count_q;
        err_d         = err_q;
        written_d     = written_q;
        cap_s         = 1'b0;
        wr_ok_s       = idx_ok(z_i) && idx_ok(z_j);
        rd_ok_s       = idx_ok(rd_i) && idx_ok(rd_j);
        was_written_s = 1'b0;
        rd_data_d     = {WIDTH{1'b0}};

        if (wr_ok_s) begin
            was_written_s = written_q[z_i][z_j];
        end else begin
            was_written_s = 1'b0;
        end

        // Registered read sees pre-capture contents on a same-edge collision.
        if (rd_ok_s && written_q[rd_i][rd_j]) begin
            rd_data_d = buf_q[rd_i][rd_j];
        end else begin
            rd_data_d = {WIDTH{1'b0}};
        end

        if (clear) begin
            state_d   = IDLE;
            count_d   = {CNT_W{1'b0}};
            err_d     = 1'b0;
            written_d = {(N * N){1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (z_stb) begin
                        cap_s   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                        if (!wr_ok_s || was_written_s) begin
                            err_d = 1'b1;
                        end else begin
                            count_d              = count_q + CNT_ONE;
                            written_d[z_i][z_j]  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACK:     state_d = RECOVER;
                RECOVER: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        full_d = (count_d == FULL_CNT);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
            full_q    <= 1'b0;
            err_q     <= 1'b0;
            written_q <= {(N * N){1'b0}};
            rd_data_q <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            count_q   <= count_d;
            full_q    <= full_d;
            err_q     <= err_d;
            written_q <= written_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Element storage; contents are qualified by the written flags, so no reset.
    always_ff @(posedge clk) begin
        if (cap_s && wr_ok_s) begin
            buf_q[z_i][z_j] <= z_out;
        end
    end

    assign z_ack        = ack_q;
    assign count        = count_q;
    assign full         = full_q;
    assign protocol_err = err_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (N=4): vector table plus hand-written
// sequences for full matrix, overwrite, clear collision and async reset.
module tb_result_collector;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int IDX_W = 2;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] z_out;
    logic [IDX_W-1:0] z_i;
    logic [IDX_W-1:0] z_j;
    logic             z_stb;
    logic             z_ack;
    logic             clear;
    logic [IDX_W-1:0] rd_i;
    logic [IDX_W-1:0] rd_j;
    logic [WIDTH-1:0] rd_data;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             protocol_err;

    int n_chk  = 0;
    int n_fail = 0;

    result_collector #(.N(N), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .z_out        (z_out),
        .z_i          (z_i),
        .z_j          (z_j),
        .z_stb        (z_stb),
        .z_ack        (z_ack),
        .clear        (clear),
        .rd_i         (rd_i),
        .rd_j         (rd_j),
        .rd_data      (rd_data),
        .count        (count),
        .full         (full),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             stb;
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
        logic [WIDTH-1:0] dat;
        logic             clr;
        logic [IDX_W-1:0] ri;
        logic [IDX_W-1:0] rj;
        logic             e_ack;
        logic [CNT_W-1:0] e_cnt;
        logic             e_full;
        logic             e_err;
        logic [WIDTH-1:0] e_rd;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input logic a, input logic [CNT_W-1:0] c,
                              input logic f, input logic e);
        chk({tag, ".ack"},   32'(z_ack),        32'(a));
        chk({tag, ".count"}, 32'(count),        32'(c));
        chk({tag, ".full"},  32'(full),         32'(f));
        chk({tag, ".err"},   32'(protocol_err), 32'(e));
    endtask

    task automatic drive_idle();
        z_stb = 1'b0;
        z_out = 32'h0;
        z_i   = 2'd0;
        z_j   = 2'd0;
    endtask

    initial begin
        rst   = 1'b0;
        clear = 1'b0;
        rd_i  = 2'd0;
        rd_j  = 2'd0;
        drive_idle();

        // Reset held for three cycles.
        for (int c = 0; c < 3; c++) step();
        chk_status("reset", 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;

        // Every location reads zero after reset.
        for (int k = 0; k < N * N; k++) begin
            rd_i = 2'(k / N);
            rd_j = 2'(k % N);
            step();
            chk($sformatf("reset_rd(%0d,%0d)", k / N, k % N), rd_data, 32'h0);
        end

        // stb  i     j     dat          clr   ri    rj    ack   cnt   full  err   rd
        vecs[0] = '{1'b1, 2'd1, 2'd2, 32'h0000_00A5, 1'b0, 2'd1, 2'd2, 1'b1, 5'd1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b0, 2'd1, 2'd2, 1'b0, 5'd1, 1'b0, 1'b0, 32'hA5};
        vecs[2] = '{1'b1, 2'd2, 2'd1, 32'h0000_0055, 1'b0, 2'd2, 2'd1, 1'b0, 5'd1, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 2'd2, 2'd1, 32'h0000_0055, 1'b0, 2'd2, 2'd1, 1'b1, 5'd2, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b0, 2'd2, 2'd1, 1'b0, 5'd2, 1'b0, 1'b0, 32'h55};
        vecs[5] = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b0, 2'd1, 2'd2, 1'b0, 5'd2, 1'b0, 1'b0, 32'hA5};
        vecs[6] = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b1, 2'd2, 2'd1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h55};
        vecs[7] = '{1'b0, 2'd0, 2'd0, 32'h0,         1'b0, 2'd2, 2'd1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0};

        for (int v = 0; v < 8; v++) begin
            z_stb = vecs[v].stb;
            z_i   = vecs[v].i;
            z_j   = vecs[v].j;
            z_out = vecs[v].dat;
            clear = vecs[v].clr;
            rd_i  = vecs[v].ri;
            rd_j  = vecs[v].rj;
            step();
            chk_status($sformatf("vec%0d", v), vecs[v].e_ack, vecs[v].e_cnt,
                       vecs[v].e_full, vecs[v].e_err);
            chk($sformatf("vec%0d.rd", v), rd_data, vecs[v].e_rd);
        end
        clear = 1'b0;
        drive_idle();

        // Full matrix, row-major, re-strobing two cycles after each ack.
        for (int k = 0; k < N * N; k++) begin
            z_stb = 1'b1;
            z_i   = 2'(k / N);
            z_j   = 2'(k % N);
            z_out = 32'(16 * (k / N) + (k % N));
            step();
            chk_status($sformatf("fill%0d", k), 1'b1, 5'(k + 1), (k == N * N - 1), 1'b0);
            drive_idle();
            step();
            chk($sformatf("fill%0d.ack_drop", k), 32'(z_ack), 32'h0);
            step();
        end
        for (int k = 0; k < N * N; k++) begin
            rd_i = 2'(k / N);
            rd_j = 2'(k % N);
            step();
            chk($sformatf("fill_rd(%0d,%0d)", k / N, k % N), rd_data, 32'(16 * (k / N) + (k % N)));
        end

        // Overwrite after full.
        z_stb = 1'b1;
        z_i   = 2'd0;
        z_j   = 2'd0;
        z_out = 32'hDEAD_BEEF;
        rd_i  = 2'd0;
        rd_j  = 2'd0;
        step();
        chk_status("ovw", 1'b1, 5'd16, 1'b1, 1'b1);
        chk("ovw.rd_old", rd_data, 32'h0);
        drive_idle();
        step();
        chk("ovw.rd_new", rd_data, 32'hDEAD_BEEF);
        chk_status("ovw.after", 1'b0, 5'd16, 1'b1, 1'b1);
        step();

        // Clear on the same edge as a strobe: not captured, accepted afterwards.
        clear = 1'b1;
        z_stb = 1'b1;
        z_i   = 2'd3;
        z_j   = 2'd3;
        z_out = 32'd7;
        rd_i  = 2'd3;
        rd_j  = 2'd3;
        step();
        chk_status("clr_coll", 1'b0, 5'd0, 1'b0, 1'b0);
        clear = 1'b0;
        step();
        chk_status("clr_acc", 1'b1, 5'd1, 1'b0, 1'b0);
        chk("clr_acc.rd_old", rd_data, 32'h0);
        drive_idle();
        step();
        chk("clr.rd33", rd_data, 32'd7);
        rd_i = 2'd0;
        rd_j = 2'd0;
        step();
        chk("clr.rd00_cleared", rd_data, 32'h0);

        // Asynchronous reset while z_ack is high.
        z_stb = 1'b1;
        z_i   = 2'd1;
        z_j   = 2'd1;
        z_out = 32'd9;
        step();
        chk_status("rst_pre", 1'b1, 5'd2, 1'b0, 1'b0);
        drive_idle();
        #1;
        rst = 1'b0;
        #1;
        chk_status("rst_async", 1'b0, 5'd0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk_status("rst_after", 1'b0, 5'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
